// File: rtl/spi_i2s_rx_deser.sv
// SPI receive deserializer: oversamples raw pins, shifts MSB-first 8/16/32-bit frames, writes them right-justified to the RX FIFO.
// Latency: SYNC_STAGES+1 clk from last sck edge to fifo_write; no backpressure, a full FIFO drops the frame and sets overflow.
module spi_i2s_rx_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  size_select,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        sck_in,
    input  logic        ss_n_in,
    input  logic        sdi_in,
    input  logic [3:0]  mem_fill_wr,
    output logic        fifo_write,
    output logic [31:0] fifo_data,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        frame_err,
    input  logic        err_clr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_d;
    logic                   sck_s;
    logic                   ss_n_s;
    logic                   sdi_s;
    logic                   sample_ev;
    logic [31:0]            shreg;
    logic [31:0]            shreg_nxt;
    logic [31:0]            frame_word;
    logic [4:0]             bit_cnt;
    logic [4:0]             last_idx;

    function automatic logic [4:0] frame_last(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd7;
            2'b01:   return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= {SYNC_STAGES{cpol}};
            sck_d    <= cpol;
            ss_sync  <= '1;
            sdi_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi_in};
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_n_s = ss_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // Modes 0/3 sample on rising sck, modes 1/2 on falling sck.
    assign sample_ev = (cpol ^ cpha) ? (~sck_s & sck_d) : (sck_s & ~sck_d);

    always_comb begin
        shreg_nxt = {shreg[30:0], sdi_s};
        case (last_idx)
            5'd7:    frame_word = {24'd0, shreg_nxt[7:0]};
            5'd15:   frame_word = {16'd0, shreg_nxt[15:0]};
            default: frame_word = shreg_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            last_idx  <= 5'd7;
            fifo_data <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Clears first so a same-cycle set below wins.
            if (ovf_clr) overflow  <= 1'b0;
            if (err_clr) frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (enable && !ss_n_s) begin
                        state    <= SHIFT;
                        last_idx <= frame_last(size_select);
                    end
                end
                SHIFT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (ss_n_s) begin
                        if (bit_cnt != 5'd0) frame_err <= 1'b1;
                        state <= IDLE;
                    end else if (sample_ev) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == last_idx) begin
                            fifo_data <= frame_word;
                            state     <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (mem_fill_wr == 4'd8) overflow <= 1'b1;
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (enable && !ss_n_s) begin
                        state    <= SHIFT;
                        last_idx <= frame_last(size_select);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_write = (state == PUSH) && (mem_fill_wr != 4'd8);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_i2s_rx_deser.sv
// Randomized self-checking bench for spi_i2s_rx_deser; expected frames come from an SPI-level model of the serial waveform.
module tb_spi_i2s_rx_deser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  size_select = 2'b00;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        sck_in = 1'b0;
    logic        ss_n_in = 1'b1;
    logic        sdi_in = 1'b0;
    logic [3:0]  mem_fill_wr = 4'd0;
    logic        fifo_write;
    logic [31:0] fifo_data;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic        frame_err;
    logic        err_clr = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic        prev_wr = 1'b0;
    logic        strobe_long = 1'b0;
    logic        watch_busy = 1'b0;
    logic        busy_gap = 1'b0;

    spi_i2s_rx_deser #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .size_select(size_select),
        .cpol(cpol), .cpha(cpha), .sck_in(sck_in), .ss_n_in(ss_n_in),
        .sdi_in(sdi_in), .mem_fill_wr(mem_fill_wr), .fifo_write(fifo_write),
        .fifo_data(fifo_data), .overflow(overflow), .ovf_clr(ovf_clr),
        .frame_err(frame_err), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observe writes away from the active edge.
    always @(negedge clk) begin
        if (!rst && fifo_write) begin
            got.push_back(fifo_data);
            if (prev_wr) strobe_long = 1'b1;
        end
        prev_wr = fifo_write;
        if (watch_busy && !busy) busy_gap = 1'b1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive MSB-first; drv_cpha picks the waveform the master uses, independent of the DUT setting.
    task automatic send_bits(input logic [31:0] val, input int nbits, input logic drv_cpha, input int h);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!drv_cpha) begin
                sdi_in = val[i];
                wait_cyc(h);
                sck_in = ~cpol;
                wait_cyc(h);
                sck_in = cpol;
            end else begin
                sck_in = ~cpol;
                wait_cyc(2);
                sdi_in = val[i];
                wait_cyc(h - 2);
                sck_in = cpol;
                wait_cyc(h);
            end
        end
    endtask

    function automatic logic [31:0] model_frame(input logic [31:0] val, input int nbits);
        logic [31:0] m;
        m = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        return val & m;
    endfunction

    task automatic frame_start();
        sck_in  = cpol;
        ss_n_in = 1'b0;
        wait_cyc(4);
    endtask

    task automatic frame_end();
        wait_cyc(6);
        ss_n_in = 1'b1;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(3);
        checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_fifo_write got %b exp 0", fifo_write); end
        checks++; if (fifo_data !== 32'd0) begin errors++; $display("FAIL reset_fifo_data got %h exp 0", fifo_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        enable = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_mode0_bytes();
        logic [31:0] vals[4];
        vals[0] = 32'hA5; vals[1] = 32'h3C;
        vals[2] = $urandom_range(0, 255); vals[3] = $urandom_range(0, 255);
        got.delete(); exp_q.delete();
        cpol = 0; cpha = 0; size_select = 2'b00;
        mem_fill_wr = 4'($urandom_range(0, 7));
        strobe_long = 1'b0; busy_gap = 1'b0;
        frame_start();
        watch_busy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_bits(vals[f], 8, 1'b0, $urandom_range(4, 7));
            exp_q.push_back(model_frame(vals[f], 8));
        end
        wait_cyc(5);
        watch_busy = 1'b0;
        frame_end();
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL mode0_count got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL mode0_data[%0d] got %h exp %h", i, got[i], exp_q[i]); end
        end
        checks++; if (strobe_long !== 1'b0) begin errors++; $display("FAIL mode0_strobe_width got multi-cycle exp one cycle"); end
        checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL mode0_busy got low mid-stream exp high"); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mode0_frame_err got %b exp 0", frame_err); end
    endtask

    task automatic test_mode3_word();
        logic [31:0] w;
        w = 32'hDEADBEEF;
        got.delete();
        cpol = 1; cpha = 1; size_select = 2'b10; sdi_in = 1'b0;
        sck_in = 1'b1; wait_cyc(6);
        frame_start();
        send_bits(w, 32, 1'b1, 5);
        frame_end();
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL mode3_count got %0d exp 1", got.size()); end
        else begin checks++; if (got[0] !== w) begin errors++; $display("FAIL mode3_data got %h exp %h", got[0], w); end end
        // Same waveform, DUT sampling on the leading (falling) edge: each sample sees the previous bit.
        got.delete();
        cpha = 0; sdi_in = 1'b0;
        wait_cyc(6);
        frame_start();
        send_bits(w, 32, 1'b1, 5);
        frame_end();
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL mode2_count got %0d exp 1", got.size()); end
        else begin checks++; if (got[0] !== {1'b0, w[31:1]}) begin errors++; $display("FAIL mode2_data got %h exp %h", got[0], {1'b0, w[31:1]}); end end
    endtask

    task automatic test_overflow();
        got.delete();
        cpol = 0; cpha = 0; size_select = 2'b01; mem_fill_wr = 4'd8;
        wait_cyc(6);
        frame_start();
        send_bits(32'h1234, 16, 1'b0, 4);
        frame_end();
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL ovf_no_write got %0d writes exp 0", got.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        ovf_clr = 1'b1; wait_cyc(1); ovf_clr = 1'b0; wait_cyc(1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
        mem_fill_wr = 4'd3;
    endtask

    task automatic test_frame_err();
        got.delete();
        size_select = 2'b00;
        frame_start();
        send_bits(32'h16, 5, 1'b0, 4);
        wait_cyc(3);
        ss_n_in = 1'b1;
        wait_cyc(6);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL ferr_no_write got %0d writes exp 0", got.size()); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b exp 1", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got busy %b exp 0", busy); end
        err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0; wait_cyc(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b exp 0", frame_err); end
        frame_start();
        send_bits(32'h81, 8, 1'b0, 4);
        frame_end();
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ferr_next_count got %0d exp 1", got.size()); end
        else begin checks++; if (got[0] !== 32'h81) begin errors++; $display("FAIL ferr_next_data got %h exp 00000081", got[0]); end end
    endtask

    task automatic test_enable_drop();
        got.delete();
        size_select = 2'b10;
        frame_start();
        send_bits(32'h2AB, 10, 1'b0, 4);
        wait_cyc(4);
        enable = 1'b0;
        wait_cyc(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy got %b exp 0", busy); end
        ss_n_in = 1'b1;
        wait_cyc(6);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL en_no_write got %0d writes exp 0", got.size()); end
        checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL en_flags got ovf=%b ferr=%b exp 0 0", overflow, frame_err); end
        enable = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_reset_mid();
        got.delete();
        size_select = 2'b00;
        frame_start();
        send_bits(32'hF, 4, 1'b0, 4);
        rst = 1'b1;
        wait_cyc(3);
        sck_in = cpol;
        rst = 1'b0;
        wait_cyc(1);
        checks++; if (fifo_write !== 1'b0 || fifo_data !== 32'd0 || overflow !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got wr=%b dat=%h ovf=%b ferr=%b busy=%b exp all 0", fifo_write, fifo_data, overflow, frame_err, busy);
        end
        wait_cyc(5);
        send_bits(32'h55, 8, 1'b0, 4);
        frame_end();
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got.size()); end
        else begin checks++; if (got[0] !== 32'h55) begin errors++; $display("FAIL rstmid_data got %h exp 00000055", got[0]); end end
    endtask

    task automatic test_random_frames();
        int nb;
        logic [31:0] v;
        for (int f = 0; f < 8; f++) begin
            got.delete(); exp_q.delete();
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            size_select = 2'($urandom_range(0, 3));
            mem_fill_wr = 4'($urandom_range(0, 7));
            nb = (size_select == 2'b00) ? 8 : (size_select == 2'b01) ? 16 : 32;
            v = $urandom;
            sck_in = cpol;
            wait_cyc(6);
            frame_start();
            send_bits(v, nb, cpha, $urandom_range(4, 7));
            exp_q.push_back(model_frame(v, nb));
            frame_end();
            checks++; if (got.size() !== 1) begin errors++; $display("FAIL rand_count[%0d] got %0d exp 1", f, got.size()); end
            else begin checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h (mode %0d size %0d)", f, got[0], exp_q[0], {cpol, cpha}, nb); end end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_bytes();
        test_mode3_word();
        test_overflow();
        test_frame_err();
        test_enable_drop();
        test_reset_mid();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
